// File: rtl/reservation_station_pkg.sv
// Shared types and width defaults for the reservation station.
package reservation_station_pkg;

  localparam int unsigned RS_DW    = 16;
  localparam int unsigned RS_TAG_W = 4;
  localparam int unsigned RS_OPC_W = 4;

  typedef struct packed {
    logic                rdy;
    logic [RS_DW-1:0]    value;
    logic [RS_TAG_W-1:0] owner;
  } rs_operand_t;

  typedef struct packed {
    logic                valid;
    logic [RS_OPC_W-1:0] opcode;
    logic [RS_TAG_W-1:0] tag;
    rs_operand_t         a;
    rs_operand_t         b;
  } rs_entry_t;

endpackage

// File: rtl/rs_operand_wakeup.sv
// Per-operand CDB snoop: captures the broadcast value when the owner tag matches.
module rs_operand_wakeup
  import reservation_station_pkg::*;
(
  input  logic                i_valid,
  input  rs_operand_t         i_op,
  input  logic                i_cdb_valid,
  input  logic [RS_TAG_W-1:0] i_cdb_tag,
  input  logic [RS_DW-1:0]    i_cdb_value,
  output rs_operand_t         o_op_c
);

  logic w_hit;

  assign w_hit = i_valid && !i_op.rdy && i_cdb_valid && (i_op.owner == i_cdb_tag);

  // Mark the operand ready and take the broadcast value on a tag hit
  always_comb begin
    o_op_c = i_op;
    if (w_hit) begin
      o_op_c.rdy   = 1'b1;
      o_op_c.value = i_cdb_value;
    end
  end

endmodule

// File: rtl/reservation_station.sv
// Collapsing-queue reservation station: dispatch, CDB wakeup, oldest-ready issue.
// Optional build macro RS_PERF_CNT_EN adds the saturating wait-cycle counter.
module reservation_station
  import reservation_station_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned DW    = RS_DW,
  parameter int unsigned TAG_W = RS_TAG_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                in_valid,
  input  logic [3:0]          in_opcode,
  input  logic [TAG_W-1:0]    in_tag,
  input  logic                in_a_valid,
  input  logic                in_b_valid,
  input  logic [DW-1:0]       in_a_value,
  input  logic [DW-1:0]       in_b_value,
  input  logic [TAG_W-1:0]    in_a_owner,
  input  logic [TAG_W-1:0]    in_b_owner,
  output logic                full,
  input  logic                cdb_valid,
  input  logic [TAG_W-1:0]    cdb_tag,
  input  logic [DW-1:0]       cdb_value,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          out_opcode,
  output logic [TAG_W-1:0]    out_tag,
  output logic [DW-1:0]       out_a,
  output logic [DW-1:0]       out_b,
  output logic [15:0]         perf_wait_cycles
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  rs_entry_t        r_q [DEPTH];
  logic [CNT_W-1:0] r_count;

  rs_entry_t        w_up  [DEPTH];
  rs_entry_t        w_pre [DEPTH];
  rs_entry_t        w_nxt [DEPTH];
  rs_operand_t      w_a_nxt [DEPTH];
  rs_operand_t      w_b_nxt [DEPTH];
  rs_entry_t        w_new;
  logic [IDX_W-1:0] w_sel;
  logic             w_any;
  logic             w_hs;
  logic             w_disp;
  logic [CNT_W-1:0] w_cnt_post;

  assign full      = (r_count == CNT_W'(DEPTH));
  assign out_valid = w_any;
  assign w_hs      = w_any && out_ready;
  assign w_disp    = in_valid && !full;

  // Oldest entry with both operands ready
  always_comb begin
    w_sel = '0;
    w_any = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (r_q[i].valid && r_q[i].a.rdy && r_q[i].b.rdy) begin
        w_any = 1'b1;
        w_sel = IDX_W'(i);
      end
    end
  end

  assign out_opcode = r_q[w_sel].opcode;
  assign out_tag    = TAG_W'(r_q[w_sel].tag);
  assign out_a      = DW'(r_q[w_sel].a.value);
  assign out_b      = DW'(r_q[w_sel].b.value);

  // Incoming entry as written by the instruction buffer
  always_comb begin
    w_new         = '0;
    w_new.valid   = 1'b1;
    w_new.opcode  = in_opcode;
    w_new.tag     = RS_TAG_W'(in_tag);
    w_new.a.rdy   = in_a_valid;
    w_new.a.value = RS_DW'(in_a_value);
    w_new.a.owner = RS_TAG_W'(in_a_owner);
    w_new.b.rdy   = in_b_valid;
    w_new.b.value = RS_DW'(in_b_value);
    w_new.b.owner = RS_TAG_W'(in_b_owner);
  end

  // Collapse over the issued slot, then append the dispatch at the new tail
  always_comb begin
    for (int i = 0; i < DEPTH - 1; i++) w_up[i] = r_q[i + 1];
    w_up[DEPTH-1] = '0;
    w_cnt_post = r_count - CNT_W'(w_hs);
    for (int i = 0; i < DEPTH; i++) begin
      w_pre[i] = (w_hs && (IDX_W'(i) >= w_sel)) ? w_up[i] : r_q[i];
      if (w_disp && (CNT_W'(i) == w_cnt_post)) w_pre[i] = w_new;
    end
  end

  // Wakeup sees post-shift positions, including the entry being dispatched
  for (genvar g = 0; g < DEPTH; g++) begin : g_wake
    rs_operand_wakeup u_wake_a (
      .i_valid     (w_pre[g].valid),
      .i_op        (w_pre[g].a),
      .i_cdb_valid (cdb_valid),
      .i_cdb_tag   (RS_TAG_W'(cdb_tag)),
      .i_cdb_value (RS_DW'(cdb_value)),
      .o_op_c      (w_a_nxt[g])
    );
    rs_operand_wakeup u_wake_b (
      .i_valid     (w_pre[g].valid),
      .i_op        (w_pre[g].b),
      .i_cdb_valid (cdb_valid),
      .i_cdb_tag   (RS_TAG_W'(cdb_tag)),
      .i_cdb_value (RS_DW'(cdb_value)),
      .o_op_c      (w_b_nxt[g])
    );
    always_comb begin
      w_nxt[g]   = w_pre[g];
      w_nxt[g].a = w_a_nxt[g];
      w_nxt[g].b = w_b_nxt[g];
    end
  end

  // Queue state; flush empties everything and overrides all other activity
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
    end else if (flush) begin
      r_count <= '0;
      for (int i = 0; i < DEPTH; i++) r_q[i] <= '0;
    end else begin
      r_count <= w_cnt_post + CNT_W'(w_disp);
      for (int i = 0; i < DEPTH; i++) r_q[i] <= w_nxt[i];
    end
  end

`ifdef RS_PERF_CNT_EN
  logic [15:0] r_perf;

  // Count occupied cycles without an issue, saturating
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf <= '0;
    end else if (flush) begin
      r_perf <= '0;
    end else if ((r_count != '0) && !w_hs && (r_perf != 16'hFFFF)) begin
      r_perf <= r_perf + 16'd1;
    end
  end

  assign perf_wait_cycles = r_perf;
`else
  assign perf_wait_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_reservation_station.sv
// Self-checking bench for reservation_station with a queue-based reference model.
module tb_reservation_station;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, in_valid, in_a_valid, in_b_valid;
  logic [3:0]  in_opcode, in_tag, in_a_owner, in_b_owner;
  logic [15:0] in_a_value, in_b_value;
  logic        full, cdb_valid, out_valid, out_ready;
  logic [3:0]  cdb_tag, out_opcode, out_tag;
  logic [15:0] cdb_value, out_a, out_b, perf_wait_cycles;

  reservation_station #(.DEPTH(DEPTH), .DW(16), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_opcode(in_opcode), .in_tag(in_tag),
    .in_a_valid(in_a_valid), .in_b_valid(in_b_valid),
    .in_a_value(in_a_value), .in_b_value(in_b_value),
    .in_a_owner(in_a_owner), .in_b_owner(in_b_owner),
    .full(full), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
    .out_tag(out_tag), .out_a(out_a), .out_b(out_b),
    .perf_wait_cycles(perf_wait_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  tag;
    bit          ar;
    logic [15:0] av;
    logic [3:0]  ao;
    bit          br;
    logic [15:0] bv;
    logic [3:0]  bo;
  } mentry_t;

  mentry_t mq[$];
  int      mperf;
  int      n_checks;
  int      n_pass;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic int model_sel();
    foreach (mq[i]) if (mq[i].ar && mq[i].br) return i;
    return -1;
  endfunction

  task automatic check_outputs();
    int s;
    logic [31:0] pexp;
    s = model_sel();
`ifdef RS_PERF_CNT_EN
    pexp = 32'(mperf);
`else
    pexp = 32'd0;
`endif
    chk("out_valid", 32'(out_valid), 32'(s >= 0));
    chk("full", 32'(full), 32'(mq.size() == DEPTH));
    chk("perf", 32'(perf_wait_cycles), pexp);
    if (s >= 0) begin
      chk("out_opcode", 32'(out_opcode), 32'(mq[s].op));
      chk("out_tag", 32'(out_tag), 32'(mq[s].tag));
      chk("out_a", 32'(out_a), 32'(mq[s].av));
      chk("out_b", 32'(out_b), 32'(mq[s].bv));
    end
  endtask

  // One clock of model behaviour from the inputs currently driven
  task automatic model_step();
    int s;
    bit hs, full_pre;
    mentry_t e;
    s = model_sel();
    hs = (s >= 0) && out_ready;
    full_pre = (mq.size() == DEPTH);
    if (flush) begin
      mq.delete();
      mperf = 0;
      return;
    end
    if (mq.size() > 0 && !hs && mperf < 65535) mperf++;
    if (hs) mq.delete(s);
    if (in_valid && !full_pre) begin
      e.op = in_opcode; e.tag = in_tag;
      e.ar = in_a_valid; e.av = in_a_valid ? in_a_value : 16'h0; e.ao = in_a_owner;
      e.br = in_b_valid; e.bv = in_b_valid ? in_b_value : 16'h0; e.bo = in_b_owner;
      mq.push_back(e);
    end
    if (cdb_valid) begin
      foreach (mq[i]) begin
        if (!mq[i].ar && mq[i].ao == cdb_tag) begin mq[i].ar = 1; mq[i].av = cdb_value; end
        if (!mq[i].br && mq[i].bo == cdb_tag) begin mq[i].br = 1; mq[i].bv = cdb_value; end
      end
    end
  endtask

  // Inputs set at posedge+1; checked mid-cycle; returns at next posedge+1
  task automatic cycle();
    #4;
    check_outputs();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; cdb_valid = 0; flush = 0;
  endtask

  task automatic disp(input logic [3:0] op, input logic [3:0] tag,
                      input bit av, input logic [15:0] aval, input logic [3:0] ao,
                      input bit bv, input logic [15:0] bval, input logic [3:0] bo);
    in_valid = 1; in_opcode = op; in_tag = tag;
    in_a_valid = av; in_a_value = aval; in_a_owner = ao;
    in_b_valid = bv; in_b_value = bval; in_b_owner = bo;
  endtask

  initial begin
    n_checks = 0; n_pass = 0; mperf = 0;
    rst_n = 0; flush = 0; in_valid = 0; in_opcode = 0; in_tag = 0;
    in_a_valid = 0; in_b_valid = 0; in_a_value = 0; in_b_value = 0;
    in_a_owner = 0; in_b_owner = 0; cdb_valid = 0; cdb_tag = 0; cdb_value = 0;
    out_ready = 0;

    // Reset values before any clock edge
    #3;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_perf", 32'(perf_wait_cycles), 32'd0);
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1;

    // Single ready dispatch issues the next cycle
    out_ready = 1;
    disp(4'h1, 4'd3, 1, 16'd5, 4'd0, 1, 16'd7, 4'd0);
    cycle();
    idle();
    chk("024_valid", 32'(out_valid), 32'd1);
    chk("024_a", 32'(out_a), 32'd5);
    chk("024_b", 32'(out_b), 32'd7);
    chk("024_tag", 32'(out_tag), 32'd3);
    cycle();
    chk("024_empty", 32'(out_valid), 32'd0);

    // Wakeup by CDB two cycles after dispatch
    disp(4'h2, 4'd6, 0, 16'd0, 4'd9, 1, 16'd1, 4'd0);
    cycle();
    idle();
    cycle();
    cdb_valid = 1; cdb_tag = 4'd9; cdb_value = 16'h00AA;
    chk("025_not_yet", 32'(out_valid), 32'd0);
    cycle();
    idle();
    chk("025_valid", 32'(out_valid), 32'd1);
    chk("025_a", 32'(out_a), 32'h00AA);
    cycle();

    // Fill, drop the overflow dispatch, then drain in order
    out_ready = 0;
    for (int t = 1; t <= 4; t++) begin
      disp(4'h3, 4'(t), 1, 16'(t * 3), 4'd0, 1, 16'(t), 4'd0);
      cycle();
    end
    chk("026_full", 32'(full), 32'd1);
    disp(4'h3, 4'd5, 1, 16'hBEEF, 4'd0, 1, 16'hBEEF, 4'd0);
    cycle();
    idle();
    chk("026_still_full", 32'(full), 32'd1);
    out_ready = 1;
    for (int k = 1; k <= 4; k++) begin
      chk("026_order", 32'(out_tag), 32'(k));
      cycle();
    end
    chk("026_drained", 32'(out_valid), 32'd0);

    // Same-cycle dispatch and matching broadcast
    disp(4'h4, 4'd8, 0, 16'd0, 4'd2, 1, 16'd9, 4'd0);
    cdb_valid = 1; cdb_tag = 4'd2; cdb_value = 16'h1234;
    cycle();
    idle();
    chk("027_valid", 32'(out_valid), 32'd1);
    chk("027_a", 32'(out_a), 32'h1234);
    cycle();

    // Flush overrides a concurrent dispatch
    out_ready = 0;
    for (int t = 0; t < 3; t++) begin
      disp(4'h5, 4'(t), 0, 16'd0, 4'd15, 1, 16'd0, 4'd0);
      cycle();
    end
    flush = 1;
    disp(4'h5, 4'd7, 1, 16'd1, 4'd0, 1, 16'd1, 4'd0);
    cycle();
    idle();
    chk("028_valid", 32'(out_valid), 32'd0);
    chk("028_full", 32'(full), 32'd0);
    chk("028_perf", 32'(perf_wait_cycles), 32'd0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      in_valid   = ($urandom_range(0, 99) < 60);
      in_opcode  = 4'($urandom);
      in_tag     = 4'($urandom);
      in_a_valid = $urandom_range(0, 1) == 1;
      in_b_valid = $urandom_range(0, 1) == 1;
      in_a_value = 16'($urandom);
      in_b_value = 16'($urandom);
      in_a_owner = 4'($urandom_range(0, 7));
      in_b_owner = 4'($urandom_range(0, 7));
      cdb_valid  = $urandom_range(0, 1) == 1;
      cdb_tag    = 4'($urandom_range(0, 7));
      cdb_value  = 16'($urandom);
      out_ready  = ($urandom_range(0, 99) < 60);
      flush      = ($urandom_range(0, 99) < 3);
      cycle();
    end
    idle();

    // Asynchronous reset with two ready entries held
    flush = 1;
    cycle();
    idle();
    out_ready = 0;
    disp(4'h6, 4'd1, 1, 16'd1, 4'd0, 1, 16'd2, 4'd0);
    cycle();
    disp(4'h6, 4'd2, 1, 16'd3, 4'd0, 1, 16'd4, 4'd0);
    cycle();
    idle();
    chk("029_pre_valid", 32'(out_valid), 32'd1);
    #1;
    rst_n = 0;
    #1;
    chk("029_valid", 32'(out_valid), 32'd0);
    chk("029_full", 32'(full), 32'd0);
    chk("029_perf", 32'(perf_wait_cycles), 32'd0);
    mq.delete();
    mperf = 0;
    @(posedge clk); #1;
    rst_n = 1;
    cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reservation_station.md
RESERVATION_STATION -- requirements
Module: reservation_station

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of entries (2..8).
REQ-002 SHALL have parameter DW, default 16, operand width.
REQ-003 SHALL have parameter TAG_W, default 4, ROB tag width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Ports (name  direction  width  meaning):
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- flush  in  1  synchronous clear of all entries
- in_valid  in  1  dispatch from the instruction buffer
- in_opcode  in  4  opcode
- in_tag  in  TAG_W  destination ROB tag
- in_a_valid, in_b_valid  in  1 each  operand ready
- in_a_value, in_b_value  in  DW each  operand value
- in_a_owner, in_b_owner  in  TAG_W each  producing ROB tag when not ready
- full  out  1  no free entry
- cdb_valid  in  1  result broadcast
- cdb_tag  in  TAG_W  broadcast tag
- cdb_value  in  DW  broadcast value
- out_valid  out  1  issue request to FXU
- out_ready  in  1  FXU accepts
- out_opcode  out  4; out_tag  out  TAG_W; out_a, out_b  out  DW each
- perf_wait_cycles  out  16  see REQ-021

Function
REQ-006 Storage SHALL be a collapsing queue; entry 0 is oldest; occupied entries are contiguous from 0.
REQ-007 full SHALL equal (count == DEPTH) from registered state only; an issue in the same cycle SHALL NOT deassert full combinationally.
REQ-008 Dispatch: in_valid && !full SHALL write the entry at index count, or count-1 if an issue handshake also occurs that cycle.
REQ-009 in_valid while full SHALL be ignored; state SHALL be unchanged by it.
REQ-010 Wakeup: each occupied entry whose operand is not ready and whose owner == cdb_tag with cdb_valid SHALL capture cdb_value and mark the operand ready next edge.
REQ-011 A dispatching entry whose not-ready owner matches the same-cycle CDB broadcast SHALL be written already ready with cdb_value.
REQ-012 Select: out_valid SHALL be 1 iff some occupied entry has both operands ready in registered state; the lowest-index such entry is selected.
REQ-013 out_opcode/out_tag/out_a/out_b SHALL reflect the selected entry; they are don't-care when out_valid is 0.
REQ-014 Issue handshake out_valid && out_ready SHALL remove the selected entry and shift all higher entries down by one at the next edge.
REQ-015 Minimum dispatch-to-issue latency SHALL be 1 cycle; an entry woken by CDB becomes eligible the cycle after the broadcast.
REQ-016 Simultaneous dispatch, issue and wakeup in one cycle SHALL all take effect; wakeup applies to entries at their post-shift positions.
REQ-017 flush SHALL empty the queue at the next edge and override dispatch, issue and wakeup that cycle.

Reset
REQ-018 While rst_n is low: count = 0, all entry valid bits 0, full = 0, out_valid = 0, perf_wait_cycles = 0.
REQ-019 Reset asserted mid-operation SHALL discard all entries immediately, without waiting for a clock edge.

Configuration
REQ-020 Macro RS_PERF_CNT_EN SHALL enable the wait-cycle counter.
REQ-021 With RS_PERF_CNT_EN defined, perf_wait_cycles SHALL increment in each cycle where count > 0 and no issue handshake occurs, saturate at 0xFFFF, and clear on flush. Without the macro, perf_wait_cycles SHALL be constant 0 and no counter logic is built.

Structure
REQ-022 The shared package SHALL hold the entry struct (valid, opcode, tag, a/b ready, value, owner), TAG_W and DW defaults, and the opcode width constant.
REQ-023 The per-entry operand wakeup compare and capture SHALL be one sub-module, rs_operand_wakeup, instantiated twice per entry.

Verification
REQ-024 Dispatch op 4'h1, tag 3, a=5 and b=7 both ready, out_ready=1 -> out_valid next cycle, out_a=5, out_b=7, out_tag=3; queue empty after.
REQ-025 Dispatch with a not ready, owner 9; two cycles later cdb_valid, tag 9, value 0x00AA -> out_valid the cycle after, out_a=0x00AA.
REQ-026 Dispatch 4 entries with out_ready=0 -> full=1; a 5th in_valid is dropped; out_ready=1 -> tags issue in dispatch order.
REQ-027 Dispatch with owner 2 in the same cycle as CDB tag 2, value 0x1234 -> entry issues next cycle with 0x1234.
REQ-028 Queue holding 3 entries, flush=1 together with in_valid=1 -> count=0 and out_valid=0 next cycle; with RS_PERF_CNT_EN, perf_wait_cycles=0.
REQ-029 Reset asserted while 2 entries are held and out_valid=1 -> out_valid=0 and full=0 before the next clock edge.
